// File: rtl/cal_serie_if.sv
// Operand/request and result/flag bundle for the bit-serial ALU cal_serie.
interface cal_serie_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             l;
  logic [1:0]       s;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             c_out;
  logic             zero;
  logic             neg;
  logic             ov;

  modport master (
    output start, a, b, l, s, c_in,
    input  busy, done, out, c_out, zero, neg, ov
  );

  modport slave (
    input  start, a, b, l, s, c_in,
    output busy, done, out, c_out, zero, neg, ov
  );
endinterface

// File: rtl/cal_serie.sv
// Bit-serial WIDTH-bit ALU: one add/logic slice plus a carry FF, LSB first.
// Define CAL_SERIE_FLAGS_EN to generate the zero/neg/ov flags (tied to 0 otherwise).
module cal_serie #(
  parameter int unsigned WIDTH = 8
) (
  input logic        clk,
  input logic        reset,
  cal_serie_if.slave bus
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_l;
  logic [1:0]       r_s;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;

  logic [IW-1:0]    w_idx;
  logic             w_ai;
  logic             w_bb;
  logic             w_bit;
  logic             w_cy_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // Single 1-bit slice operating on bit r_cnt of the latched operands
  always_comb begin
    w_idx     = r_cnt[IW-1:0];
    w_ai      = r_a[w_idx];
    w_bb      = r_b[w_idx] ^ r_s[0];
    w_bit     = 1'b0;
    w_cy_nxt  = 1'b0;
    if (!r_l) begin
      w_bit    = w_ai ^ w_bb ^ r_cy;
      w_cy_nxt = (w_ai & w_bb) | (w_ai & r_cy) | (w_bb & r_cy);
    end else begin
      unique case (r_s)
        2'b00:   w_bit = w_ai & r_b[w_idx];
        2'b01:   w_bit = w_ai | r_b[w_idx];
        2'b10:   w_bit = w_ai ^ r_b[w_idx];
        default: w_bit = ~w_ai;
      endcase
    end
    w_last    = (r_cnt == CW'(WIDTH - 1));
    w_res_nxt = {w_bit, r_res[WIDTH-1:1]};
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_nxt = StRun;
      StRun:   if (w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

`ifdef CAL_SERIE_FLAGS_EN
  logic r_zero;
  logic r_neg;
  logic r_ov;

  // Carry into the MSB is the carry FF while the last bit is processed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ov   <= 1'b0;
    end else if (r_state == StRun && w_last) begin
      r_zero <= (w_res_nxt == '0);
      r_neg  <= w_bit;
      r_ov   <= ~r_l & (r_cy ^ w_cy_nxt);
    end
  end

  assign bus.zero = r_zero;
  assign bus.neg  = r_neg;
  assign bus.ov   = r_ov;
`else
  assign bus.zero = 1'b0;
  assign bus.neg  = 1'b0;
  assign bus.ov   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_l     <= 1'b0;
      r_s     <= 2'b00;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_out   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_l   <= bus.l;
            r_s   <= bus.s;
            r_cy  <= bus.c_in & ~bus.l;
            r_cnt <= '0;
          end
        end
        StRun: begin
          r_res <= w_res_nxt;
          r_cy  <= w_cy_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Results land as DONE is entered so they are valid during the done pulse
          if (w_last) begin
            r_out  <= w_res_nxt;
            r_cout <= w_cy_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (r_state == StRun);
  assign bus.done  = (r_state == StDone);
  assign bus.out   = r_out;
  assign bus.c_out = r_cout;

endmodule

// File: tb/tb_cal_serie.sv
// Directed self-checking bench for cal_serie (WIDTH=8).
module tb_cal_serie;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

`ifdef CAL_SERIE_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  cal_serie_if #(.WIDTH(8)) bus ();

  cal_serie #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic l,
                       input logic [1:0] s, input logic cin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.l     = l;
    bus.s     = s;
    bus.c_in  = cin;
  endtask

  // Waits (bounded) for done; returns with the caller sitting on the done negedge
  task automatic wait_done(input string tag, output int nbusy, output logic got);
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
      else if (bus.busy) nbusy++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] e_out, input logic e_cout,
                              input logic e_zero, input logic e_neg, input logic e_ov);
    check({tag, "_out"},   32'(bus.out),   32'(e_out));
    check({tag, "_cout"},  32'(bus.c_out), 32'(e_cout));
    check({tag, "_flags"}, {29'd0, bus.zero, bus.neg, bus.ov},
          {29'd0, e_zero & FL, e_neg & FL, e_ov & FL});
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic l, input logic [1:0] s, input logic cin,
                       input logic [7:0] e_out, input logic e_cout,
                       input logic e_zero, input logic e_neg, input logic e_ov);
    int   nbusy;
    logic got;
    drive(a, b, l, s, cin);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the latched copy must be used
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.l     = ~l;
    bus.s     = ~s;
    bus.c_in  = ~cin;
    wait_done(tag, nbusy, got);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check_result(tag, e_out, e_cout, e_zero, e_neg, e_ov);
    @(negedge clk);
    check({tag, "_single_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_out_held"}, 32'(bus.out), 32'(e_out));
  endtask

  initial begin
    int   nbusy;
    int   npulse;
    logic got;
    logic [7:0] seen_out;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.l     = 1'b0;
    bus.s     = 2'b00;
    bus.c_in  = 1'b0;

    // 1. Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {18'd0, bus.busy, bus.done, bus.out, bus.c_out, bus.zero, bus.neg, bus.ov},
            32'd0);
    end

    // 2./3. Arithmetic
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 2'b00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    do_op("sub_05_05", 8'h05, 8'h05, 1'b0, 2'b01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // 4. Logic ops
    do_op("and", 8'hF0, 8'h3C, 1'b1, 2'b00, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("or",  8'hF0, 8'h3C, 1'b1, 2'b01, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("xor", 8'hF0, 8'h3C, 1'b1, 2'b10, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("not", 8'hF0, 8'h3C, 1'b1, 2'b11, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start during the done cycle is accepted one edge later
    drive(8'h10, 8'h20, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("b2b_first", nbusy, got);
    drive(8'h03, 8'h04, 1'b0, 2'b00, 1'b0);
    check("b2b_first_out", 32'(bus.out), 32'h30);
    @(negedge clk);
    check("b2b_not_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("b2b_accepted_next", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("b2b_second", nbusy, got);
    check("b2b_second_busy", 32'(nbusy), 32'd7);
    check_result("b2b_second", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 5. Start during RUN is ignored
    drive(8'h01, 8'h01, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    drive(8'hFF, 8'hFF, 1'b0, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    npulse   = 0;
    seen_out = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        npulse++;
        seen_out = bus.out;
      end
    end
    check("ignore_pulses", 32'(npulse), 32'd1);
    check("ignore_out", 32'(seen_out), 32'h02);

    // 6. Reset mid-RUN
    drive(8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_run", {27'd0, bus.busy, bus.done, bus.c_out, bus.zero | bus.neg, bus.ov},
          32'd0);
    check("rst_mid_out", 32'(bus.out), 32'd0);
    reset  = 1'b0;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) npulse++;
    end
    check("rst_no_done", 32'(npulse), 32'd0);
    do_op("post_rst_add", 8'h12, 8'h34, 1'b0, 2'b00, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
